maxbw_crc_sink: RTL and testbench
=================================

# maxbw_crc_sink

Downstream consumer of the DDR input capture stage. Each clock it absorbs one captured pair: the falling-edge sample `in_lo` and the rising-edge sample `in_hi`, 32 bits per cycle. It folds every pair into a running CRC-16 and counts accepted pairs. On command it streams a 6-byte result record over an 8-bit valid/ready port, so the bench or pin logic can prove full-bandwidth capture without observing every sample.

## Interface
- `CNT_W`, default 24: width of the pair counter. The counter saturates and does not wrap. Fixed at 24 for the record format.
- `clk`  in  1: single clock. All state updates on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: the `in_lo`/`in_hi` pair is valid this cycle.
- `in_lo`  in  16: falling-edge sample, already synchronised into `clk`.
- `in_hi`  in  16: rising-edge sample.
- `cmd`  in  2: sampled every cycle. 00 NOP, 01 ARM, 10 STOP, 11 READ.
- `out_data`  out  8: result byte. Registered.
- `out_valid`  out  1: `out_data` holds a byte. Registered.
- `out_ready`  in  1: the consumer accepts the byte. A transfer happens when `out_valid` and `out_ready` are both high on a rising edge.
- `busy`  out  1: high while in RUN. Registered.

## Operation
- **CRC:** CRC-16/CCITT-FALSE.
  - Polynomial 0x1021, init 0xFFFF, MSB-first, no reflection, no final XOR.
  - Per valid cycle the CRC consumes 32 bits: `in_lo[15:0]` MSB first, then `in_hi[15:0]` MSB first.
  - Byte view: `in_lo[15:8]`, `in_lo[7:0]`, `in_hi[15:8]`, `in_hi[7:0]`.
  - Combinational 32-bit unrolled update, one pair per cycle, no stall.
- **Counter:** `count` increments by 1 per accepted pair and saturates at 0xFFFFFF.
- **States:** IDLE (reset), RUN, HOLD, DUMP.
  - **IDLE:**
    - ARM: clear CRC to 0xFFFF and `count` to 0, go to RUN.
    - READ: go to DUMP.
    - STOP and NOP: no effect.
    - `in_valid` is ignored.
  - **RUN:** a pair is absorbed on every cycle with `in_valid` high.
    - STOP: the pair in the same cycle is still absorbed, then go to HOLD.
    - ARM: restart. CRC and `count` are cleared, and the pair in the same cycle is discarded.
    - READ: ignored.
  - **HOLD:** `in_valid` is ignored.
    - READ: go to DUMP with byte index 0.
    - ARM: go to RUN, cleared.
  - **DUMP:** emit the record bytes in this order.
    - 0: `crc[15:8]`
    - 1: `crc[7:0]`
    - 2: `count[23:16]`
    - 3: `count[15:8]`
    - 4: `count[7:0]`
    - 5: 0xA5 trailer
  - **DUMP transitions:**
    - The index advances only on a transfer.
    - After byte 5 is transferred, go to HOLD. The record can be re-read with another READ.
    - ARM aborts: `out_valid` drops next cycle and the block goes to RUN, cleared.
    - STOP and READ are ignored.
    - `in_valid` is ignored.
- CRC and `count` are never modified outside RUN, except by ARM clearing them.

## Timing
- **Reset values:**
  - `out_data` = 0x00, `out_valid` = 0, `busy` = 0.
  - State IDLE, CRC 0xFFFF, `count` 0, byte index 0.
  - Reset takes effect immediately on `rst_n` falling, including mid-DUMP.
- **ARM:** ARM sampled at cycle N gives `busy` = 1 at N+1. The first absorbable pair is the one at N+1.
- **STOP:** STOP at N gives `busy` = 0 at N+1. The pair at N is included in the record.
- **READ:** READ at N gives `out_valid` = 1 with byte 0 at N+1.
- **Byte stream:**
  - Each transfer at cycle M presents the next byte at M+1.
  - With `out_ready` held high, the record takes exactly 6 consecutive cycles.
  - `out_valid` = 0 on the cycle after byte 5 is transferred.
- **Stall:** while `out_ready` is low, `out_data` and `out_valid` must hold stable.
- **Throughput:** one pair per cycle in RUN. There is no backpressure on the input side.

## Test plan
- **Empty record:** reset, READ, `out_ready`=1 → bytes FF FF 00 00 00 A5, then `out_valid`=0. A second READ repeats the identical record.
- **Known data:** ARM; 2 valid cycles with `in_lo`/`in_hi` = 0x3132/0x3334 then 0x3536/0x3738; STOP; READ → CRC bytes equal the bench CRC-16/CCITT-FALSE model over bytes 31..38, count bytes 00 00 02, trailer A5.
- **STOP boundary:** ARM; 5 valid cycles, with STOP asserted alongside the 5th; then `in_valid` held high for 10 more cycles → count reads 00 00 05.
- **Backpressure:** during DUMP, toggle `out_ready` pseudo-randomly → each byte stays stable while stalled, the byte order is exact, and exactly 6 transfers occur.
- **Abort and restart:**
  - ARM during DUMP after 2 bytes → `out_valid`=0 next cycle and `busy`=1.
  - Then 3 valid pairs, STOP, READ → count 00 00 03.
- **Saturation and reset:**
  - Force `count` to 0xFFFFFE, then 3 valid pairs → count reads FF FF FF.
  - Assert `rst_n`=0 mid-DUMP → `out_valid`=0 immediately, and the next READ returns FF FF 00 00 00 A5.

Source files
------------

// File: rtl/maxbw_crc_sink_if.sv
// Capture-pair input, command and byte-stream result port of the CRC sink.
interface maxbw_crc_sink_if;
  logic        in_valid;
  logic [15:0] in_lo;
  logic [15:0] in_hi;
  logic [1:0]  cmd;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  modport master (
    output in_valid, in_lo, in_hi, cmd, out_ready,
    input  out_data, out_valid, busy
  );

  modport slave (
    input  in_valid, in_lo, in_hi, cmd, out_ready,
    output out_data, out_valid, busy
  );
endinterface

// File: rtl/maxbw_crc_sink.sv
// Folds one DDR capture pair per cycle into a CRC-16/CCITT-FALSE, counts pairs,
// and streams a 6-byte {crc, count, 0xA5} record on command.
module maxbw_crc_sink #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  maxbw_crc_sink_if.slave  bus
);

  localparam logic [1:0] CMD_ARM  = 2'b01;
  localparam logic [1:0] CMD_STOP = 2'b10;
  localparam logic [1:0] CMD_READ = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DUMP} state_t;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [15:0]      crc_q;
  logic [CNT_W-1:0] count;
  logic             vld_d, load, clr, absorb;
  logic [7:0]       rec_byte;
  logic [23:0]      cnt24;
  logic             xfer;

  // 32 message bits per pair, in_lo first, each half MSB first.
  function automatic logic [15:0] crc32_upd(input logic [15:0] c, input logic [31:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 31; i >= 0; i--)
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction

  assign cnt24 = 24'(count);
  assign xfer  = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vld_d   = bus.out_valid;
    load    = 1'b0;
    clr     = 1'b0;
    absorb  = 1'b0;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (bus.cmd == CMD_ARM) begin
          clr     = 1'b1;
          state_d = S_RUN;
        end else if (bus.cmd == CMD_READ) begin
          state_d = S_DUMP;
          idx_d   = 3'd0;
          vld_d   = 1'b1;
          load    = 1'b1;
        end
      end
      S_RUN: begin
        // ARM restarts and drops the same-cycle pair; STOP still keeps it.
        if (bus.cmd == CMD_ARM) begin
          clr = 1'b1;
        end else begin
          absorb = bus.in_valid;
          if (bus.cmd == CMD_STOP) state_d = S_HOLD;
        end
      end
      S_DUMP: begin
        if (bus.cmd == CMD_ARM) begin
          clr     = 1'b1;
          state_d = S_RUN;
          vld_d   = 1'b0;
          idx_d   = 3'd0;
        end else if (xfer) begin
          if (idx_q == 3'd5) begin
            vld_d   = 1'b0;
            idx_d   = 3'd0;
            state_d = S_HOLD;
          end else begin
            idx_d = idx_q + 3'd1;
            load  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Byte selected by the index the stream is about to present.
  always_comb begin
    case (idx_d)
      3'd0:    rec_byte = crc_q[15:8];
      3'd1:    rec_byte = crc_q[7:0];
      3'd2:    rec_byte = cnt24[23:16];
      3'd3:    rec_byte = cnt24[15:8];
      3'd4:    rec_byte = cnt24[7:0];
      default: rec_byte = 8'hA5;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= 3'd0;
      crc_q         <= 16'hFFFF;
      count         <= '0;
      bus.out_data  <= 8'h00;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      bus.out_valid <= vld_d;
      bus.busy      <= (state_d == S_RUN);
      if (load) bus.out_data <= rec_byte;
      if (clr) begin
        crc_q <= 16'hFFFF;
        count <= '0;
      end else if (absorb) begin
        crc_q <= crc32_upd(crc_q, {bus.in_lo, bus.in_hi});
        if (count != {CNT_W{1'b1}}) count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_maxbw_crc_sink.sv
// Randomised bench for maxbw_crc_sink against a byte-queue CRC/count model.
module tb_maxbw_crc_sink;
  localparam logic [1:0] NOP = 2'b00, ARM = 2'b01, STOP = 2'b10, READ = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [7:0]  m_bytes[$];
  logic [23:0] m_cnt;

  always #5 clk = ~clk;

  maxbw_crc_sink_if bus ();

  maxbw_crc_sink #(.CNT_W(24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference CRC over the whole absorbed byte stream, byte-at-a-time form.
  function automatic logic [15:0] crc_model();
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (m_bytes[i]) begin
      c = c ^ {m_bytes[i], 8'h00};
      for (int b = 0; b < 8; b++)
        c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic m_clear();
    m_bytes.delete();
    m_cnt = 24'd0;
  endtask

  task automatic m_push(input logic [15:0] lo, input logic [15:0] hi);
    m_bytes.push_back(lo[15:8]);
    m_bytes.push_back(lo[7:0]);
    m_bytes.push_back(hi[15:8]);
    m_bytes.push_back(hi[7:0]);
    if (m_cnt != 24'hFFFFFF) m_cnt++;
  endtask

  // One clock with the given input; absorbed into the model only when told so.
  task automatic step(input logic v, input logic [15:0] lo, input logic [15:0] hi,
                      input logic [1:0] c, input bit take);
    bus.in_valid = v;
    bus.in_lo    = lo;
    bus.in_hi    = hi;
    bus.cmd      = c;
    cycle();
    if (take && v) m_push(lo, hi);
    bus.in_valid = 1'b0;
    bus.cmd      = NOP;
  endtask

  task automatic do_arm(input string tag);
    step(1'b1, 16'($urandom), 16'($urandom), ARM, 1'b0);
    m_clear();
    chk({tag, "_busy_arm"}, 32'(bus.busy), 32'd1);
  endtask

  task automatic run_pairs(input string tag, input int n, input bit rnd_valid, input bit stop_last);
    logic v;
    for (int i = 0; i < n; i++) begin
      v = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      step(v, 16'($urandom), 16'($urandom), (stop_last && i == n - 1) ? STOP : NOP, 1'b1);
    end
    if (stop_last) chk({tag, "_busy_stop"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic do_stop(input string tag);
    step(1'b0, 16'h0, 16'h0, STOP, 1'b0);
    chk({tag, "_busy_stop"}, 32'(bus.busy), 32'd0);
  endtask

  // READ then drain the record; abort_after >= 0 issues ARM after that many bytes.
  task automatic read_rec(input string tag, input bit rnd_ready, input int abort_after);
    logic [7:0]  exp[6];
    logic [15:0] c;
    logic [7:0]  held;
    logic        hv, rdy;
    int          xfers, cyc;
    c = crc_model();
    exp = '{c[15:8], c[7:0], m_cnt[23:16], m_cnt[15:8], m_cnt[7:0], 8'hA5};
    bus.out_ready = 1'b0;
    step(1'b0, 16'h0, 16'h0, READ, 1'b0);
    chk({tag, "_vld_read"}, 32'(bus.out_valid), 32'd1);
    xfers = 0;
    cyc   = 0;
    while (xfers < 6 && cyc < 200) begin
      if (abort_after == xfers) begin
        bus.out_ready = 1'b0;
        step(1'b1, 16'($urandom), 16'($urandom), ARM, 1'b0);
        m_clear();
        chk({tag, "_abort_vld"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_abort_busy"}, 32'(bus.busy), 32'd1);
        return;
      end
      rdy  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_ready = rdy;
      held = bus.out_data;
      hv   = bus.out_valid;
      cycle();
      cyc++;
      if (rdy && hv) begin
        chk($sformatf("%s_byte%0d", tag, xfers), 32'(held), 32'(exp[xfers]));
        xfers++;
      end else begin
        chk({tag, "_stall"}, {23'd0, bus.out_valid, bus.out_data}, {23'd0, 1'b1, held});
      end
    end
    bus.out_ready = 1'b0;
    chk({tag, "_xfers"}, 32'(xfers), 32'd6);
    chk({tag, "_vld_done"}, 32'(bus.out_valid), 32'd0);
    if (!rnd_ready) chk({tag, "_cycles"}, 32'(cyc), 32'd6);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_lo     = 16'h0;
    bus.in_hi     = 16'h0;
    bus.cmd       = NOP;
    bus.out_ready = 1'b0;
    m_clear();
    repeat (3) cycle();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    cycle();

    // Idle ignores pairs, STOP and NOP.
    step(1'b1, 16'hDEAD, 16'hBEEF, NOP, 1'b0);
    step(1'b1, 16'h1234, 16'h5678, STOP, 1'b0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    read_rec("empty", 1'b0, -1);
    read_rec("empty2", 1'b0, -1);

    // Known ASCII data "12345678".
    do_arm("known");
    step(1'b1, 16'h3132, 16'h3334, NOP, 1'b1);
    step(1'b1, 16'h3536, 16'h3738, NOP, 1'b1);
    do_stop("known");
    read_rec("known", 1'b0, -1);

    // STOP alongside the 5th pair, then input keeps running in HOLD.
    do_arm("stopb");
    run_pairs("stopb", 5, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 16'($urandom), 16'($urandom), NOP, 1'b0);
    read_rec("stopb", 1'b0, -1);

    // Random traffic, READ in RUN ignored, ARM in RUN discards its pair.
    for (int r = 0; r < 3; r++) begin
      do_arm("rnd");
      run_pairs("rnd", 20, 1'b1, 1'b0);
      step(1'b1, 16'($urandom), 16'($urandom), READ, 1'b1);
      chk("rnd_read_in_run", 32'(bus.out_valid), 32'd0);
      run_pairs("rnd", 10, 1'b1, 1'b0);
      if (r == 1) begin
        step(1'b1, 16'($urandom), 16'($urandom), ARM, 1'b0);
        m_clear();
        run_pairs("rnd", 8, 1'b1, 1'b0);
      end
      run_pairs("rnd", 6, 1'b1, 1'b1);
      read_rec("rnd_bp", 1'b1, -1);
    end

    // Abort mid-record then restart.
    read_rec("abort", 1'b0, 2);
    run_pairs("abort", 3, 1'b0, 1'b0);
    do_stop("abort");
    read_rec("abort_rd", 1'b1, -1);

    // Counter saturation.
    do_arm("sat");
    force dut.count = 24'hFFFFFE;
    cycle();
    release dut.count;
    m_cnt = 24'hFFFFFE;
    run_pairs("sat", 3, 1'b0, 1'b0);
    do_stop("sat");
    read_rec("sat", 1'b0, -1);

    // Asynchronous reset mid-record.
    bus.out_ready = 1'b0;
    step(1'b0, 16'h0, 16'h0, READ, 1'b0);
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_vld", 32'(bus.out_valid), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    cycle();
    #2;
    rst_n = 1'b1;
    m_clear();
    cycle();
    read_rec("post_rst", 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
